alu_result_collector: RTL

Synthesizable sink for the 8-bit ALU's outputs. It samples the result bus, opcode tag and status flags on a capture strobe and buffers them in a small FIFO. A downstream consumer drains the FIFO through a valid/ready read port. The block also keeps sticky flag history and a saturating drop counter, so a controller or on-chip checker can consume ALU results at its own pace.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_res_fifo.sv | 54 +++++
 rtl/alu_result_collector.sv | 108 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU result collector.
//   - flag bit indices within the 6-bit FLAGS bus
//   - FLAG_W / OP_W field widths
//   - alu_entry_t: packed FIFO entry layout {op, result, flags[, par]}
// Optional feature macro: ALU_RESULT_PARITY_EN adds the per-entry parity bit.
package alu_pkg;

  localparam int FLAG_W = 6;
  localparam int OP_W   = 4;
  localparam int RES_W  = 8;  // default ALU F bus width

  // Bit positions inside FLAGS = {Overflow, CarryOut, Zero, LT, GT, EQUAL}
  localparam int FLAG_EQUAL = 0;
  localparam int FLAG_GT    = 1;
  localparam int FLAG_LT    = 2;
  localparam int FLAG_ZERO  = 3;
  localparam int FLAG_CARRY = 4;
  localparam int FLAG_OVF   = 5;

  // Entry layout for the default result width. The collector packs the same
  // field order generically so that W can be overridden.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [RES_W-1:0]  result;
    logic [FLAG_W-1:0] flags;
`ifdef ALU_RESULT_PARITY_EN
    logic              par;
`endif
  } alu_entry_t;

endpackage

// File: rtl/alu_res_fifo.sv
// alu_res_fifo: generic DEPTH x ENTRY_W circular buffer.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, pop     write / read strobes; the caller never pushes into a full
//                 buffer without a same-cycle pop, and never pops when empty
//   wr_data       entry written at push
//   rd_data       head entry; driven to 0 while the buffer is empty
//   count         occupancy, 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap by overflow.
module alu_res_fifo #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 18
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ENTRY_W-1:0]         wr_data,
  output logic [ENTRY_W-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  // Storage needs no reset: it is only observable through rd_data, which is
  // masked whenever count is zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;  // idle, or push+pop cancel out
      endcase
    end
  end

  assign rd_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/alu_result_collector.sv
// alu_result_collector: captures ALU outputs {S, F, FLAGS} on CAP into a
// small FIFO drained through a valid/ready read port, and keeps sticky flag
// history plus a saturating count of captures lost while full.
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   CAP, S, F, FLAGS    capture strobe and the ALU outputs to sample
//   CLR                 clear STICKY and DROP_CNT
//   RD_READY, RD_VALID  read handshake
//   RD_F, RD_S, RD_FLAGS head entry fields (0 while empty)
//   COUNT, FULL         occupancy and COUNT == DEPTH
//   DROP_CNT            captures lost while full, saturating at 255
//   STICKY              OR of FLAGS of every accepted capture since RST/CLR
//   RD_PAR              even parity over {S, F, FLAGS} of the head entry
//                       (only with ALU_RESULT_PARITY_EN defined)
//
// Read handshake: an entry transfers on a rising edge where RD_VALID and
// RD_READY are both high; RD_* stay stable until that transfer, RD_VALID
// never depends on RD_READY, and RD_READY with RD_VALID low is ignored.
module alu_result_collector
  import alu_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   CAP,
  input  logic [OP_W-1:0]        S,
  input  logic [W-1:0]           F,
  input  logic [FLAG_W-1:0]      FLAGS,
  input  logic                   CLR,
  input  logic                   RD_READY,
  output logic                   RD_VALID,
  output logic [W-1:0]           RD_F,
  output logic [OP_W-1:0]        RD_S,
  output logic [FLAG_W-1:0]      RD_FLAGS,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic                   FULL,
  output logic [7:0]             DROP_CNT,
`ifdef ALU_RESULT_PARITY_EN
  output logic                   RD_PAR,
`endif
  output logic [FLAG_W-1:0]      STICKY
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef ALU_RESULT_PARITY_EN
  localparam int ENTRY_W = OP_W + W + FLAG_W + 1;
`else
  localparam int ENTRY_W = OP_W + W + FLAG_W;
`endif

  logic               push;
  logic               pop;
  logic               drop;
  logic [ENTRY_W-1:0] wr_data;
  logic [ENTRY_W-1:0] rd_data;
  logic [FLAG_W-1:0]  sticky_next;
  logic [7:0]         drop_next;

  assign RD_VALID = (COUNT != '0);
  assign FULL     = (COUNT == CNT_W'(DEPTH));
  assign pop      = RD_VALID && RD_READY;
  // A full buffer still accepts a capture when the head leaves this cycle.
  assign push     = CAP && (!FULL || pop);
  assign drop     = CAP && FULL && !pop;

`ifdef ALU_RESULT_PARITY_EN
  assign wr_data = {S, F, FLAGS, ^{S, F, FLAGS}};
  assign RD_PAR  = rd_data[0];
  assign {RD_S, RD_F, RD_FLAGS} = rd_data[ENTRY_W-1:1];
`else
  assign wr_data = {S, F, FLAGS};
  assign {RD_S, RD_F, RD_FLAGS} = rd_data;
`endif

  alu_res_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .count   (COUNT)
  );

  // CLR acts first, then the same-cycle push/drop accumulates on top.
  always_comb begin
    sticky_next = CLR ? '0 : STICKY;
    drop_next   = CLR ? '0 : DROP_CNT;
    if (push) sticky_next = sticky_next | FLAGS;
    if (drop && (drop_next != 8'hFF)) drop_next = drop_next + 8'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      STICKY   <= '0;
      DROP_CNT <= '0;
    end else begin
      STICKY   <= sticky_next;
      DROP_CNT <= drop_next;
    end
  end

endmodule
